keypad_scan_arbiter: RTL

Scans a 4x4 matrix keypad one row at a time and debounces the result across whole-keypad scans. Each confirmed key press is delivered as a single event on a valid/ready handshake. The block sits between the keypad pins and downstream consumers such as the dot-matrix display logic. It replaces free-running "last key seen" latching with press/release detection, ghost rejection and overrun reporting.

---
 rtl/keypad_scan_arbiter_if.sv | 25 ++
 rtl/keypad_scan_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_arbiter_if.sv
// Key event channel between the keypad scanner and its consumer.
// The scanner drives code/valid/held/overrun; the consumer drives ready.
interface keypad_scan_arbiter_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan_arbiter.sv
// 4x4 matrix keypad scanner with whole-scan debounce, ghost rejection and a
// single-entry valid/ready event output that flags overwritten events.
module keypad_scan_arbiter #(
    parameter int unsigned SCAN_TICKS     = 250000,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              keypadCol,
    output logic [3:0]              keypadRow,
    keypad_scan_arbiter_if.master   key_if
);

    localparam int unsigned TickW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CntW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(SCAN_TICKS - 1);
    localparam logic [CntW-1:0]  CntDone  = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);

    typedef enum logic [1:0] {StIdle, StPressChk, StPressed, StRelChk} state_e;

    logic [TickW-1:0] tick_q;
    logic [3:0]       row_q;
    // Lows seen so far this scan: 0 = none, 1 = exactly one, 2 = more than one.
    logic [1:0]       acc_cnt_q;
    logic [3:0]       acc_code_q;

    state_e           state_q;
    logic [3:0]       cand_q;
    logic [CntW-1:0]  cnt_q;
    logic             key_held_q;

    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             overrun_q;

    logic             sample;
    logic             scan_end;
    logic [3:0]       col_low;
    logic             row_hit;
    logic             row_one;
    logic [1:0]       tot_cnt;
    logic [3:0]       tot_code;
    logic             scan_none;
    logic             scan_single;
    logic [CntW-1:0]  cnt_inc;
    logic             emit;
    logic             transfer;

    function automatic logic [3:0] map_key(input logic [3:0] row, input logic [3:0] lows);
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
        case (row)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case (lows)
            4'b0001: c = 2'd0;
            4'b0010: c = 2'd1;
            4'b0100: c = 2'd2;
            default: c = 2'd3;
        endcase
        case ({r, c})
            4'h0: code = 4'h7;
            4'h1: code = 4'h4;
            4'h2: code = 4'h1;
            4'h3: code = 4'h0;
            4'h4: code = 4'h8;
            4'h5: code = 4'h5;
            4'h6: code = 4'h2;
            4'h7: code = 4'hA;
            4'h8: code = 4'h9;
            4'h9: code = 4'h6;
            4'hA: code = 4'h3;
            4'hB: code = 4'hB;
            4'hC: code = 4'hC;
            4'hD: code = 4'hD;
            4'hE: code = 4'hE;
            4'hF: code = 4'hF;
        endcase
        return code;
    endfunction

    assign sample   = (tick_q == TickLast);
    assign scan_end = sample && (row_q == 4'b0111);
    assign col_low  = ~keypadCol;
    assign row_hit  = |col_low;
    assign row_one  = row_hit && ((col_low & (col_low - 4'd1)) == 4'd0);
    assign cnt_inc  = cnt_q + CntOne;
    assign transfer = key_valid_q && key_if.key_ready;

    // Fold the current row sample into the running scan result.
    always_comb begin
        tot_cnt  = acc_cnt_q;
        tot_code = acc_code_q;
        if (row_hit) begin
            if (row_one && (acc_cnt_q == 2'd0)) begin
                tot_cnt  = 2'd1;
                tot_code = map_key(row_q, col_low);
            end else begin
                tot_cnt = 2'd2;
            end
        end
    end

    assign scan_none   = (tot_cnt == 2'd0);
    assign scan_single = (tot_cnt == 2'd1);

    // A press is confirmed when the candidate has been seen DEBOUNCE_SCANS times.
    always_comb begin
        emit = 1'b0;
        if (scan_end && scan_single) begin
            case (state_q)
                StIdle:     emit = (DEBOUNCE_SCANS == 1);
                StPressChk: emit = (tot_code == cand_q) && (cnt_inc == CntDone);
                default:    emit = 1'b0;
            endcase
        end
    end

    // Row dwell counter, row rotation and per-scan accumulation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_q     <= '0;
            row_q      <= 4'b1110;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (sample) begin
            tick_q <= '0;
            row_q  <= {row_q[2:0], row_q[3]};
            if (scan_end) begin
                acc_cnt_q  <= 2'd0;
                acc_code_q <= 4'd0;
            end else begin
                acc_cnt_q  <= tot_cnt;
                acc_code_q <= tot_code;
            end
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    // Debounce FSM, advanced only at scan ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cand_q     <= 4'd0;
            cnt_q      <= '0;
            key_held_q <= 1'b0;
        end else if (scan_end) begin
            case (state_q)
                StIdle: begin
                    if (scan_single) begin
                        cand_q <= tot_code;
                        cnt_q  <= CntOne;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_q    <= StPressed;
                            key_held_q <= 1'b1;
                        end else begin
                            state_q <= StPressChk;
                        end
                    end
                end
                StPressChk: begin
                    if (scan_single) begin
                        if (tot_code == cand_q) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CntDone) begin
                                state_q    <= StPressed;
                                key_held_q <= 1'b1;
                            end
                        end else begin
                            cand_q <= tot_code;
                            cnt_q  <= CntOne;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StPressed: begin
                    if (scan_none) begin
                        cnt_q <= CntOne;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_q    <= StIdle;
                            key_held_q <= 1'b0;
                        end else begin
                            state_q <= StRelChk;
                        end
                    end
                end
                StRelChk: begin
                    if (scan_none) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CntDone) begin
                            state_q    <= StIdle;
                            key_held_q <= 1'b0;
                        end
                    end else begin
                        state_q <= StPressed;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Single-entry event register; a new event always wins over a pending one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (emit) begin
                key_code_q  <= tot_code;
                key_valid_q <= 1'b1;
            end else if (transfer) begin
                key_valid_q <= 1'b0;
            end
            if (transfer) begin
                overrun_q <= 1'b0;
            end else if (emit && key_valid_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign keypadRow        = row_q;
    assign key_if.key_code  = key_code_q;
    assign key_if.key_valid = key_valid_q;
    assign key_if.key_held  = key_held_q;
    assign key_if.overrun   = overrun_q;

endmodule
